lsu_mem_ctrl: RTL and testbench
===============================

// Module: lsu_mem_ctrl
// PURPOSE
//  Load/store unit between execute stage and data memory port. Accepts one RV32I load/store
//  request, aligns store data and byte enables to the word, runs a req/gnt/rvalid memory
//  handshake, then right-aligns and sign/zero-extends load data. Detects misalignment,
//  bad funct3 and memory timeout. One transaction in flight; pipeline stalls on req_ready=0.
// PARAMETERS
//  TIMEOUT_CYC  64  max cycles in WAIT before rsp_err; counter width $clog2(TIMEOUT_CYC+1)
// PORTS
//  clk         in   1   single clock, all state on rising edge
//  rst_n       in   1   asynchronous, active-low reset
//  req_valid   in   1   execute-stage request valid
//  req_ready   out  1   =1 only in IDLE; transfer when req_valid&&req_ready
//  req_we      in   1   1=store, 0=load
//  req_funct3  in   3   RV32I funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW)
//  req_addr    in   32  byte address
//  req_wdata   in   32  store data, right-aligned
//  mem_req     out  1   memory request, held until mem_gnt
//  mem_gnt     in   1   memory accepted request this cycle
//  mem_we      out  1   memory write
//  mem_addr    out  32  {req_addr[31:2],2'b00}
//  mem_be      out  4   byte enables
//  mem_wdata   out  32  lane-aligned store data
//  mem_rvalid  in   1   read data valid / write ack (one pulse per granted request)
//  mem_rdata   in   32  raw memory word
//  rsp_valid   out  1   one-cycle response pulse, no backpressure
//  rsp_rdata   out  32  extended load data (0 for stores and errors)
//  rsp_err     out  1   misaligned, illegal funct3 or timeout; qualifies rsp_valid
// BEHAVIOUR
//  Reset (async): state=IDLE; mem_req/mem_we/rsp_valid/rsp_err=0; mem_addr/be/wdata/rsp_rdata=0.
//  FSM: IDLE -> ISSUE on accept if legal; IDLE -> RESP(err) if illegal (no mem access).
//   ISSUE: mem_req=1; on mem_gnt -> WAIT. No timeout in ISSUE.
//   WAIT: mem_req=0; on mem_rvalid -> RESP; cnt==TIMEOUT_CYC-1 without rvalid -> RESP(err).
//   RESP: rsp_valid=1 for exactly one cycle -> IDLE.
//  Latency: accept cycle N; gnt in N+1, rvalid in N+2 -> rsp_valid in N+3 (minimum).
//   Error on accept -> rsp_valid in N+1.
//  Registered at accept: off=req_addr[1:0], funct3, we, mem_addr, mem_be, mem_wdata.
//  Legality: loads 000,001,010,100,101; stores 000,001,010; else illegal.
//   Misaligned: halfword with off[0]=1; word with off!=0.
//  Store: SB be=4'b0001<<off, SH 4'b0011<<off, SW 4'b1111; wdata = masked src << 8*off.
//  Load: w = mem_rdata >> 8*off; LB sext w[7:0], LBU zext w[7:0], LH sext w[15:0],
//   LHU zext w[15:0], LW w. Captured into rsp_rdata on mem_rvalid in WAIT.
//  mem_rvalid outside WAIT: ignored (assertion flags it). mem_gnt outside ISSUE: ignored.
//  mem_gnt and mem_rvalid same cycle in ISSUE: gnt taken, rvalid ignored (memory must not do this).
//  Timeout: rsp_err=1, rsp_rdata=0; late mem_rvalid then arrives in IDLE and is ignored.
//  Reset asserted mid-transaction: abandon immediately, no response, mem_req drops async.
// STRUCTURE
//  lsu_pkg: funct3 localparams (F3_B/H/W/BU/HU), state encoding (IDLE/ISSUE/WAIT/RESP),
//   byte-enable constants.
//  Sub-module lsu_lane_align (combinational): store be/wdata generation and load
//   shift+extend; FSM, timeout counter and registers stay in lsu_mem_ctrl.
// TESTING
//  SB addr=0x103, wdata=0xAB, gnt N+1, rvalid N+2 -> mem_be=1000, mem_wdata=0xAB000000,
//   mem_addr=0x100, rsp_valid N+3, err=0.
//  LH addr=0x202, rdata=0x8001_1234 -> rsp_rdata=0xFFFF8001; LHU -> 0x00008001.
//  LW addr=0x301 -> no mem_req, rsp_valid N+1 with rsp_err=1; funct3=011 load -> same.
//  gnt withheld 5 cycles -> mem_req stays 1, mem_addr stable, req_ready=0 throughout.
//  No rvalid for TIMEOUT_CYC cycles -> rsp_err=1, rsp_rdata=0; late rvalid ignored.
//  rst_n low while in WAIT -> all outputs 0 at once; next request completes normally.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: funct3 codes, FSM states,
// byte-enable patterns and the request legality check.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } lsu_state_e;

    // Unsigned variants only exist for loads; alignment follows access size.
    function automatic logic lsu_req_legal(input logic       we,
                                           input logic [2:0] funct3,
                                           input logic [1:0] off);
        logic legal;
        case (funct3)
            F3_B:    legal = 1'b1;
            F3_H:    legal = !off[0];
            F3_W:    legal = (off == 2'b00);
            F3_BU:   legal = !we;
            F3_HU:   legal = !we && !off[0];
            default: legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane steering: store data/enables into word lanes and
// load data back out of its lane with sign or zero extension.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [2:0]  st_funct3_i,
    input  logic [1:0]  st_off_i,
    input  logic [31:0] st_wdata_i,
    output logic [3:0]  st_be_o,
    output logic [31:0] st_wdata_o,
    input  logic [2:0]  ld_funct3_i,
    input  logic [1:0]  ld_off_i,
    input  logic [31:0] ld_rdata_i,
    output logic [31:0] ld_data_o
);

    logic [31:0] ld_word;

    always_comb begin
        st_be_o    = BE_WORD;
        st_wdata_o = st_wdata_i;
        case (st_funct3_i)
            F3_B, F3_BU: begin
                st_be_o    = BE_BYTE << st_off_i;
                st_wdata_o = {24'b0, st_wdata_i[7:0]} << {st_off_i, 3'b000};
            end
            F3_H, F3_HU: begin
                st_be_o    = BE_HALF << st_off_i;
                st_wdata_o = {16'b0, st_wdata_i[15:0]} << {st_off_i, 3'b000};
            end
            default: begin
                st_be_o    = BE_WORD;
                st_wdata_o = st_wdata_i;
            end
        endcase
    end

    always_comb begin
        ld_word   = ld_rdata_i >> {ld_off_i, 3'b000};
        ld_data_o = ld_word;
        case (ld_funct3_i)
            F3_B:    ld_data_o = {{24{ld_word[7]}}, ld_word[7:0]};
            F3_BU:   ld_data_o = {24'b0, ld_word[7:0]};
            F3_H:    ld_data_o = {{16{ld_word[15]}}, ld_word[15:0]};
            F3_HU:   ld_data_o = {16'b0, ld_word[15:0]};
            default: ld_data_o = ld_word;
        endcase
    end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Single-outstanding load/store controller: accepts one request, drives a
// req/gnt/rvalid memory handshake with timeout, returns one response pulse.
module lsu_mem_ctrl
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYC = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        mem_req,
    input  logic        mem_gnt,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    lsu_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       off_q, off_d;
    logic [2:0]       f3_q, f3_d;
    logic             we_q, we_d;
    logic [31:0]      addr_q, addr_d;
    logic [3:0]       be_q, be_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             err_q, err_d;
    logic             orphan_q, orphan_d;

    logic [3:0]       st_be;
    logic [31:0]      st_wdata;
    logic [31:0]      ld_data;

    lsu_lane_align u_lane_align (
        .st_funct3_i (req_funct3),
        .st_off_i    (req_addr[1:0]),
        .st_wdata_i  (req_wdata),
        .st_be_o     (st_be),
        .st_wdata_o  (st_wdata),
        .ld_funct3_i (f3_q),
        .ld_off_i    (off_q),
        .ld_rdata_i  (mem_rdata),
        .ld_data_o   (ld_data)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        off_d    = off_q;
        f3_d     = f3_q;
        we_d     = we_q;
        addr_d   = addr_q;
        be_d     = be_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        orphan_d = orphan_q;

        // A timed-out request may still see its late rvalid; it is consumed here.
        if (mem_rvalid && state_q != WAIT) begin
            orphan_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    off_d   = req_addr[1:0];
                    f3_d    = req_funct3;
                    we_d    = req_we;
                    rdata_d = '0;
                    if (lsu_req_legal(req_we, req_funct3, req_addr[1:0])) begin
                        addr_d  = {req_addr[31:2], 2'b00};
                        be_d    = st_be;
                        wdata_d = st_wdata;
                        err_d   = 1'b0;
                        state_d = ISSUE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = RESP;
                    end
                end
            end
            ISSUE: begin
                if (mem_gnt) begin
                    cnt_d   = '0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (mem_rvalid) begin
                    rdata_d = we_q ? 32'h0 : ld_data;
                    err_d   = 1'b0;
                    state_d = RESP;
                end else if (cnt_q == CNT_LAST) begin
                    rdata_d  = '0;
                    err_d    = 1'b1;
                    orphan_d = 1'b1;
                    state_d  = RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            off_q    <= '0;
            f3_q     <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            be_q     <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            orphan_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            off_q    <= off_d;
            f3_q     <= f3_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            be_q     <= be_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            orphan_q <= orphan_d;
        end
    end

    // Handshake outputs decode from state so an async reset drops them at once.
    assign req_ready = (state_q == IDLE);
    assign mem_req   = (state_q == ISSUE);
    assign mem_we    = mem_req && we_q;
    assign mem_addr  = addr_q;
    assign mem_be    = be_q;
    assign mem_wdata = wdata_q;
    assign rsp_valid = (state_q == RESP);
    assign rsp_err   = rsp_valid && err_q;
    assign rsp_rdata = rdata_q;

    a_rvalid_only_in_wait: assert property (
        @(posedge clk) disable iff (!rst_n)
        (mem_rvalid && state_q != WAIT) |-> orphan_q
    ) else $error("lsu_mem_ctrl: mem_rvalid with no outstanding request");

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
module tb_lsu_mem_ctrl;

    localparam int TIMEOUT_CYC = 64;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        mem_req;
    logic        mem_gnt;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    typedef struct {
        string       tag;
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } sb_t;

    sb_t sb[$];
    int  checks   = 0;
    int  failures = 0;
    int  cyc      = 0;

    lsu_mem_ctrl #(.TIMEOUT_CYC(TIMEOUT_CYC)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .mem_req    (mem_req),
        .mem_gnt    (mem_gnt),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Response scoreboard: every rsp_valid cycle pops exactly one expectation.
    always @(negedge clk) begin
        if (rst_n && rsp_valid) begin
            if (sb.size() == 0) begin
                check_eq("rsp_unexpected", 32'd1, 32'd0);
            end else begin
                sb_t e;
                e = sb.pop_front();
                check_eq({e.tag, "_rdata"}, rsp_rdata, e.rdata);
                check_eq({e.tag, "_err"}, {31'b0, rsp_err}, {31'b0, e.err});
                check_eq({e.tag, "_cycle"}, cyc, e.cyc);
            end
        end
    end

    // kind: 0 = normal access, 1 = rejected at accept, 2 = memory never answers
    task automatic run_txn(input string tag, input logic we, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input int kind, input int gdly, input int rdly,
                           input logic [31:0] mrdata, input logic [3:0] ebe,
                           input logic [31:0] ewdata, input logic [31:0] erdata);
        sb_t e;
        int  t_acc;
        logic [31:0] eaddr;
        eaddr      = addr & 32'hFFFF_FFFC;
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        @(posedge clk);
        #1;
        t_acc     = cyc;
        req_valid = 1'b0;
        e.tag     = tag;
        e.rdata   = erdata;
        e.err     = (kind != 0);
        if (kind == 0)      e.cyc = t_acc + 2 + gdly + rdly;
        else if (kind == 1) e.cyc = t_acc;
        else                e.cyc = t_acc + 1 + gdly + TIMEOUT_CYC;
        sb.push_back(e);

        if (kind == 1) begin
            @(negedge clk);
            check_eq({tag, "_noreq"}, {31'b0, mem_req}, 32'd0);
        end else begin
            for (int i = 0; i < gdly; i++) begin
                @(negedge clk);
                check_eq({tag, "_hold_req"}, {31'b0, mem_req}, 32'd1);
                check_eq({tag, "_hold_addr"}, mem_addr, eaddr);
                check_eq({tag, "_hold_ready"}, {31'b0, req_ready}, 32'd0);
                @(posedge clk);
                #1;
            end
            mem_gnt = 1'b1;
            @(negedge clk);
            check_eq({tag, "_req"}, {31'b0, mem_req}, 32'd1);
            check_eq({tag, "_we"}, {31'b0, mem_we}, {31'b0, we});
            check_eq({tag, "_addr"}, mem_addr, eaddr);
            check_eq({tag, "_be"}, {28'b0, mem_be}, {28'b0, ebe});
            check_eq({tag, "_wdata"}, mem_wdata, ewdata);
            @(posedge clk);
            #1;
            mem_gnt = 1'b0;
            @(negedge clk);
            check_eq({tag, "_req_wait"}, {31'b0, mem_req}, 32'd0);
            if (kind == 0) begin
                repeat (rdly) @(posedge clk);
                #1;
                mem_rvalid = 1'b1;
                mem_rdata  = mrdata;
                @(posedge clk);
                #1;
                mem_rvalid = 1'b0;
                mem_rdata  = 32'h0;
            end else begin
                repeat (TIMEOUT_CYC + 1) @(posedge clk);
                #1;
                mem_rvalid = 1'b1;
                mem_rdata  = mrdata;
                @(posedge clk);
                #1;
                mem_rvalid = 1'b0;
                mem_rdata  = 32'h0;
                @(negedge clk);
                check_eq({tag, "_late_idle"}, {31'b0, req_ready}, 32'd1);
            end
        end
        for (int i = 0; i < 200 && sb.size() != 0; i++) @(posedge clk);
        if (sb.size() != 0) begin
            check_eq({tag, "_no_response"}, sb.size(), 32'd0);
            sb.delete();
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
        #12;
        check_eq("rst_ready", {31'b0, req_ready}, 32'd1);
        check_eq("rst_req", {31'b0, mem_req}, 32'd0);
        check_eq("rst_we", {31'b0, mem_we}, 32'd0);
        check_eq("rst_addr", mem_addr, 32'h0);
        check_eq("rst_be", {28'b0, mem_be}, 32'h0);
        check_eq("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check_eq("rst_rsp_rdata", rsp_rdata, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        //       tag        we    f3      addr          wdata         kind g r  mrdata        be       ewdata        erdata
        run_txn("sb_103",   1'b1, 3'b000, 32'h0000_0103, 32'h1234_56AB, 0, 0, 0, 32'hDEAD_BEEF, 4'b1000, 32'hAB00_0000, 32'h0);
        run_txn("lh_202",   1'b0, 3'b001, 32'h0000_0202, 32'h0,         0, 0, 0, 32'h8001_1234, 4'b1100, 32'h0,         32'hFFFF_8001);
        run_txn("lhu_202",  1'b0, 3'b101, 32'h0000_0202, 32'h0,         0, 0, 1, 32'h8001_1234, 4'b1100, 32'h0,         32'h0000_8001);
        run_txn("lw_mis",   1'b0, 3'b010, 32'h0000_0301, 32'h0,         1, 0, 0, 32'h0,         4'b0000, 32'h0,         32'h0);
        run_txn("ld_f3_011",1'b0, 3'b011, 32'h0000_0300, 32'h0,         1, 0, 0, 32'h0,         4'b0000, 32'h0,         32'h0);
        run_txn("lb_401",   1'b0, 3'b000, 32'h0000_0401, 32'h0,         0, 0, 0, 32'h0000_F000, 4'b0010, 32'h0,         32'hFFFF_FFF0);
        run_txn("lbu_401",  1'b0, 3'b100, 32'h0000_0401, 32'h0,         0, 0, 0, 32'h0000_F000, 4'b0010, 32'h0,         32'h0000_00F0);
        run_txn("lw_gnt5",  1'b0, 3'b010, 32'h0000_0500, 32'h0,         0, 5, 2, 32'hCAFE_BABE, 4'b1111, 32'h0,         32'hCAFE_BABE);
        run_txn("sh_602",   1'b1, 3'b001, 32'h0000_0602, 32'hFFFF_BEEF, 0, 1, 0, 32'h1111_1111, 4'b1100, 32'hBEEF_0000, 32'h0);
        run_txn("sw_700",   1'b1, 3'b010, 32'h0000_0700, 32'h1122_3344, 0, 0, 3, 32'h0,         4'b1111, 32'h1122_3344, 32'h0);
        run_txn("st_f3_100",1'b1, 3'b100, 32'h0000_0700, 32'h55,        1, 0, 0, 32'h0,         4'b0000, 32'h0,         32'h0);
        run_txn("sh_mis",   1'b1, 3'b001, 32'h0000_0601, 32'h1234,      1, 0, 0, 32'h0,         4'b0000, 32'h0,         32'h0);
        run_txn("lw_tmo",   1'b0, 3'b010, 32'h0000_0800, 32'h0,         2, 1, 0, 32'h7777_7777, 4'b1111, 32'h0,         32'h0);

        // Reset while waiting for read data: no response, everything clears.
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'b010;
        req_addr   = 32'h0000_0A04;
        req_wdata  = 32'h0BAD_F00D;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        mem_gnt   = 1'b1;
        @(posedge clk);
        #1;
        mem_gnt = 1'b0;
        check_eq("mid_addr_before", mem_addr, 32'h0000_0A04);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_req", {31'b0, mem_req}, 32'd0);
        check_eq("mid_rst_we", {31'b0, mem_we}, 32'd0);
        check_eq("mid_rst_addr", mem_addr, 32'h0);
        check_eq("mid_rst_be", {28'b0, mem_be}, 32'h0);
        check_eq("mid_rst_wdata", mem_wdata, 32'h0);
        check_eq("mid_rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check_eq("mid_rst_rsp_err", {31'b0, rsp_err}, 32'd0);
        check_eq("mid_rst_rsp_rdata", rsp_rdata, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_eq("post_rst_ready", {31'b0, req_ready}, 32'd1);

        run_txn("lw_post",  1'b0, 3'b010, 32'h0000_0900, 32'h0,         0, 0, 0, 32'h0102_0304, 4'b1111, 32'h0,         32'h0102_0304);

        repeat (3) @(posedge clk);
        check_eq("sb_empty_end", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
